// File: rtl/wb_retire.sv
// Write-back / retire stage: registered register-file write port, halt-detect FSM and an
// optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_retire (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        latchn,
    input  logic        valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] aluResult_i,
    input  logic [31:0] memReadValue_i,
    input  logic [11:0] pc_i,
    input  logic        probablyHalt_i,
    output logic        RF_WE,
    output logic [4:0]  RF_WA,
    output logic [31:0] RF_WD,
    output logic        HALT,
    output logic [31:0] NUM_INST
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [1:0] {StRun, StArmed, StHalted} state_e;

    state_e      state_q, state_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_wa_q, rf_wa_d;
    logic [31:0] rf_wd_q, rf_wd_d;
    logic        retire;
    logic        writes_rd;

    assign retire = valid_i && !latchn && (state_q != StHalted);

    always_comb begin
        writes_rd = 1'b0;
        case (opcode_i)
            OpReg, OpImm, OpLoad, OpJal, OpJalr, OpLui, OpAuipc: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        rf_we_d = retire && writes_rd && (rd_i != 5'd0);
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (retire) begin
            rf_wa_d = rd_i;
            if (opcode_i == OpLoad) begin
                rf_wd_d = memReadValue_i;
            end else if (opcode_i == OpJal || opcode_i == OpJalr) begin
                rf_wd_d = {20'd0, pc_i} + 32'd4;
            end else begin
                rf_wd_d = aluResult_i;
            end
        end
    end

    // Two consecutive halt-flagged retirements halt; bubbles neither arm nor disarm.
    always_comb begin
        state_d = state_q;
        if (retire) begin
            case (state_q)
                StRun:   state_d = probablyHalt_i ? StArmed : StRun;
                StArmed: state_d = probablyHalt_i ? StHalted : StRun;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StRun;
            rf_we_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] num_inst_q, num_inst_d;

    always_comb begin
        num_inst_d = retire ? num_inst_q + 32'd1 : num_inst_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            num_inst_q <= 32'd0;
        end else begin
            num_inst_q <= num_inst_d;
        end
    end

    assign NUM_INST = num_inst_q;
`else
    assign NUM_INST = 32'd0;
`endif

    assign RF_WE = rf_we_q;
    assign RF_WA = rf_wa_q;
    assign RF_WD = rf_wd_q;
    assign HALT  = (state_q == StHalted);

endmodule

// File: tb/tb_wb_retire.sv
// Self-checking bench for wb_retire: directed scenarios plus randomized retire streams checked
// against a behavioural retire model; counter checks follow WB_RETIRE_CNT_EN.
module tb_wb_retire;

    logic        CLK, RSTn, latchn, valid_i, probablyHalt_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [31:0] aluResult_i, memReadValue_i;
    logic [11:0] pc_i;
    logic        RF_WE, HALT;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD, NUM_INST;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Reference model
    logic        m_we, m_halted, m_armed;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_cnt;

    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                            7'b0110111, 7'b0010111, 7'b0100011, 7'b1100011};

    wb_retire dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .latchn         (latchn),
        .valid_i        (valid_i),
        .opcode_i       (opcode_i),
        .rd_i           (rd_i),
        .aluResult_i    (aluResult_i),
        .memReadValue_i (memReadValue_i),
        .pc_i           (pc_i),
        .probablyHalt_i (probablyHalt_i),
        .RF_WE          (RF_WE),
        .RF_WA          (RF_WA),
        .RF_WD          (RF_WD),
        .HALT           (HALT),
        .NUM_INST       (NUM_INST)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic op_writes(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                          7'b0110111, 7'b0010111};
    endfunction

    task automatic model_clear();
        m_we = 0; m_wa = 0; m_wd = 0; m_halted = 0; m_armed = 0; m_cnt = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
    task automatic step(input logic v, input logic ln, input logic [6:0] op, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [11:0] pc,
                        input logic ph);
        logic ret;
        valid_i = v; latchn = ln; opcode_i = op; rd_i = rd;
        aluResult_i = alu; memReadValue_i = mem; pc_i = pc; probablyHalt_i = ph;
        @(posedge CLK);
        ret  = v && !ln && !m_halted;
        m_we = ret && op_writes(op) && (rd != 0);
        if (ret) begin
            m_wa = rd;
            if (op == 7'b0000011) m_wd = mem;
            else if (op == 7'b1101111 || op == 7'b1100111) m_wd = 32'(pc) + 32'd4;
            else m_wd = alu;
            m_cnt = m_cnt + 1;
            if (ph) begin
                if (m_armed) m_halted = 1;
                m_armed = 1;
            end else begin
                m_armed = 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 7'b0010011, 5'd9, 32'hDEAD_0001, 32'hDEAD_0002, 12'h555, 1'b1);
    endtask

    task automatic test_reset();
        RSTn = 0; valid_i = 1; latchn = 0; opcode_i = 7'b0110011; rd_i = 5'd7;
        aluResult_i = 32'h1; memReadValue_i = 0; pc_i = 0; probablyHalt_i = 1;
        model_clear();
        repeat (3) @(negedge CLK);
        nvec++;
        if ({RF_WE, RF_WA, RF_WD, HALT, NUM_INST} !== 71'd0) begin
            nerr++;
            $display("FAIL reset: we=%b wa=%0d wd=%h halt=%b cnt=%h, required all zero",
                     RF_WE, RF_WA, RF_WD, HALT, NUM_INST);
        end
        RSTn = 1;
    endtask

    task automatic test_addi();
        // First retirement immediately after reset release
        step(1'b1, 1'b0, 7'b0010011, 5'd5, 32'h1234, 32'h0, 12'h0, 1'b0);
        nvec++;
        if (RF_WE !== 1'b1 || RF_WA !== 5'd5 || RF_WD !== 32'h1234 || NUM_INST !== exp_cnt()) begin
            nerr++;
            $display("FAIL addi: we=%b wa=%0d wd=%h cnt=%h, required 1 5 00001234 %h",
                     RF_WE, RF_WA, RF_WD, NUM_INST, exp_cnt());
        end
        bubble();
        nvec++;
        if (RF_WE !== 1'b0 || RF_WA !== 5'd5 || RF_WD !== 32'h1234 || HALT !== 1'b0) begin
            nerr++;
            $display("FAIL addi_bubble: we=%b wa=%0d wd=%h halt=%b, required 0 5 00001234 0",
                     RF_WE, RF_WA, RF_WD, HALT);
        end
        // latchn high is also a bubble
        step(1'b1, 1'b1, 7'b0110011, 5'd12, 32'h7777, 32'h0, 12'h0, 1'b0);
        nvec++;
        if (RF_WE !== 1'b0 || RF_WA !== 5'd5 || RF_WD !== 32'h1234 || NUM_INST !== exp_cnt()) begin
            nerr++;
            $display("FAIL latchn_bubble: we=%b wa=%0d wd=%h cnt=%h, required 0 5 00001234 %h",
                     RF_WE, RF_WA, RF_WD, NUM_INST, exp_cnt());
        end
    endtask

    task automatic test_jal_load();
        step(1'b1, 1'b0, 7'b1101111, 5'd1, 32'hAAAA, 32'hBBBB, 12'h0FC, 1'b0);
        nvec++;
        if (RF_WE !== 1'b1 || RF_WA !== 5'd1 || RF_WD !== 32'h100) begin
            nerr++;
            $display("FAIL jal: we=%b wa=%0d wd=%h, required 1 1 00000100", RF_WE, RF_WA, RF_WD);
        end
        step(1'b1, 1'b0, 7'b1100111, 5'd2, 32'hAAAA, 32'hBBBB, 12'hFFF, 1'b0);
        nvec++;
        if (RF_WE !== 1'b1 || RF_WA !== 5'd2 || RF_WD !== 32'h1003) begin
            nerr++;
            $display("FAIL jalr_pcmax: we=%b wa=%0d wd=%h, required 1 2 00001003",
                     RF_WE, RF_WA, RF_WD);
        end
        step(1'b1, 1'b0, 7'b0000011, 5'd3, 32'h40, 32'hFFFF_FF80, 12'h010, 1'b0);
        nvec++;
        if (RF_WE !== 1'b1 || RF_WA !== 5'd3 || RF_WD !== 32'hFFFF_FF80) begin
            nerr++;
            $display("FAIL load: we=%b wa=%0d wd=%h, required 1 3 ffffff80", RF_WE, RF_WA, RF_WD);
        end
    endtask

    task automatic test_no_write();
        logic [31:0] c0;
        c0 = m_cnt;
        step(1'b1, 1'b0, 7'b0100011, 5'd8, 32'h55, 32'h66, 12'h020, 1'b0);
        nvec++;
        if (RF_WE !== 1'b0 || RF_WA !== 5'd8 || RF_WD !== 32'h55) begin
            nerr++;
            $display("FAIL store: we=%b wa=%0d wd=%h, required 0 8 00000055", RF_WE, RF_WA, RF_WD);
        end
        step(1'b1, 1'b0, 7'b0110011, 5'd0, 32'h99, 32'h66, 12'h024, 1'b0);
        nvec++;
        if (RF_WE !== 1'b0 || RF_WA !== 5'd0 || NUM_INST !== exp_cnt()) begin
            nerr++;
            $display("FAIL rd0_add: we=%b wa=%0d cnt=%h, required 0 0 %h",
                     RF_WE, RF_WA, NUM_INST, exp_cnt());
        end
`ifdef WB_RETIRE_CNT_EN
        nvec++;
        if (NUM_INST !== c0 + 32'd2) begin
            nerr++;
            $display("FAIL count_nonwriting: cnt=%h, required %h", NUM_INST, c0 + 32'd2);
        end
`endif
    endtask

    task automatic pulse_reset_check(input string name);
        #2 RSTn = 0;
        #1;
        nvec++;
        if (RF_WE !== 1'b0 || HALT !== 1'b0 || NUM_INST !== 32'd0 || RF_WD !== 32'd0) begin
            nerr++;
            $display("FAIL %s: we=%b halt=%b cnt=%h wd=%h, required all zero",
                     name, RF_WE, HALT, NUM_INST, RF_WD);
        end
        model_clear();
        @(negedge CLK);
        RSTn = 1;
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        step(1'b1, 1'b0, 7'b0010011, 5'd4, 32'h11, 32'h0, 12'h100, 1'b1);
        bubble();
        nvec++;
        if (HALT !== 1'b0) begin
            nerr++;
            $display("FAIL armed_not_halted: halt=%b, required 0", HALT);
        end
        // Second halt-flagged instruction still retires and writes
        step(1'b1, 1'b0, 7'b0110011, 5'd6, 32'h22, 32'h0, 12'h104, 1'b1);
        nvec++;
        if (HALT !== 1'b1 || RF_WE !== 1'b1 || RF_WA !== 5'd6 || RF_WD !== 32'h22) begin
            nerr++;
            $display("FAIL halt_enter: halt=%b we=%b wa=%0d wd=%h, required 1 1 6 00000022",
                     HALT, RF_WE, RF_WA, RF_WD);
        end
        frozen = NUM_INST;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 7'b0010011, 5'(10 + i), 32'h33, 32'h0, 12'h108, 1'(i));
            nvec++;
            if (HALT !== 1'b1 || RF_WE !== 1'b0 || RF_WA !== 5'd6 || NUM_INST !== frozen ||
                NUM_INST !== exp_cnt()) begin
                nerr++;
                $display("FAIL halted_frozen[%0d]: halt=%b we=%b wa=%0d cnt=%h, required 1 0 6 %h",
                         i, HALT, RF_WE, RF_WA, NUM_INST, frozen);
            end
        end
        pulse_reset_check("reset_from_halted");
        step(1'b1, 1'b0, 7'b0010011, 5'd4, 32'h44, 32'h0, 12'h200, 1'b1);
        step(1'b1, 1'b0, 7'b0010011, 5'd4, 32'h45, 32'h0, 12'h204, 1'b0);
        step(1'b1, 1'b0, 7'b0010011, 5'd4, 32'h46, 32'h0, 12'h208, 1'b1);
        nvec++;
        if (HALT !== 1'b0 || RF_WE !== 1'b1 || RF_WD !== 32'h46) begin
            nerr++;
            $display("FAIL disarm: halt=%b we=%b wd=%h, required 0 1 00000046", HALT, RF_WE, RF_WD);
        end
        // Armed now; halt with a writing instruction so RF_WE=1, then reset mid-cycle
        step(1'b1, 1'b0, 7'b0110111, 5'd31, 32'h47, 32'h0, 12'h20C, 1'b1);
        nvec++;
        if (HALT !== 1'b1 || RF_WE !== 1'b1) begin
            nerr++;
            $display("FAIL halt_after_disarm: halt=%b we=%b, required 1 1", HALT, RF_WE);
        end
        pulse_reset_check("reset_drops_we");
    endtask

    task automatic test_random();
        int idx;
        int halted_cycles;
        halted_cycles = 0;
        for (int n = 0; n < 400; n++) begin
            idx = int'($urandom_range(0, 8));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), ops[idx],
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
                 12'($urandom), 1'($urandom_range(0, 3) == 0));
            nvec++;
            if (RF_WE !== m_we || RF_WA !== m_wa || RF_WD !== m_wd || HALT !== m_halted ||
                NUM_INST !== exp_cnt()) begin
                nerr++;
                $display("FAIL random[%0d]: we=%b wa=%0d wd=%h halt=%b cnt=%h, required %b %0d %h %b %h",
                         n, RF_WE, RF_WA, RF_WD, HALT, NUM_INST,
                         m_we, m_wa, m_wd, m_halted, exp_cnt());
            end
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            if (halted_cycles == 4) begin
                pulse_reset_check("random_reset");
                halted_cycles = 0;
            end
        end
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_wrap();
        logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
        dut.num_inst_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 7'b0100011, 5'd1, 32'h0, 32'h0, 12'h0, 1'b0);
            nvec++;
            if (NUM_INST !== want[i] || NUM_INST !== m_cnt) begin
                nerr++;
                $display("FAIL wrap[%0d]: cnt=%h, required %h", i, NUM_INST, want[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_jal_load();
        test_no_write();
        test_halt();
`ifdef WB_RETIRE_CNT_EN
        test_wrap();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
